// File: rtl/logical_shift_64bit_if.sv
// Request/result bundle for the 64-bit logical shifter.
interface logical_shift_64bit_if;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned AMT_W  = 6;

  logic              in_valid;
  logic              shift_dir;
  logic [DATA_W-1:0] data;
  logic [AMT_W-1:0]  shift_amount;
  logic              out_valid;
  logic [DATA_W-1:0] shifted_data;

  // Requester side: drives operands, observes the registered result
  modport master (
    output in_valid, shift_dir, data, shift_amount,
    input  out_valid, shifted_data
  );

  // Shifter side
  modport slave (
    input  in_valid, shift_dir, data, shift_amount,
    output out_valid, shifted_data
  );
endinterface

// File: rtl/logical_shift_64bit.sv
// 64-bit zero-fill barrel shifter, left/right, one-cycle registered result.
module logical_shift_64bit (
  input  logic                    clk,
  input  logic                    rst_n,
  logical_shift_64bit_if.slave    bus
);
  localparam int unsigned DATA_W = 64;
  localparam int unsigned AMT_W  = 6;

  logic [DATA_W-1:0] w_result;
  logic [DATA_W-1:0] r_shifted_data;
  logic              r_out_valid;

  // Six stages; stage k moves the operand by 2^k when shift_amount[k] is set
  always_comb begin
    w_result = bus.data;
    for (int k = 0; k < int'(AMT_W); k++) begin
      if (bus.shift_amount[k]) begin
        if (bus.shift_dir) w_result = w_result >> (2 ** k);
        else               w_result = w_result << (2 ** k);
      end
    end
  end

  // Output registers: reset clears, valid request captures, idle holds data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shifted_data <= '0;
      r_out_valid    <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) r_shifted_data <= w_result;
    end
  end

  assign bus.out_valid    = r_out_valid;
  assign bus.shifted_data = r_shifted_data;
endmodule

// File: tb/tb_logical_shift_64bit.sv
// Scoreboard bench for logical_shift_64bit.
module tb_logical_shift_64bit;
  logic clk;
  logic rst_n;

  logical_shift_64bit_if bus ();

  logical_shift_64bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_data = 64'h0;

  // Count one comparison and report it on mismatch
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_shift(input logic dir, input logic [63:0] d,
                                            input logic [5:0] amt);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (!dir && i >= int'(amt))      r[i] = d[i - int'(amt)];
      if (dir && i + int'(amt) <= 63)  r[i] = d[i + int'(amt)];
    end
    return r;
  endfunction

  // Drive one cycle, push expectation, then compare after the edge
  task automatic step(input string tag, input logic r, input logic v, input logic dir,
                      input logic [63:0] d, input logic [5:0] amt);
    logic exp_v;
    rst_n            = r;
    bus.in_valid     = v;
    bus.shift_dir    = dir;
    bus.data         = d;
    bus.shift_amount = amt;
    exp_v = r && v;
    if (exp_v) exp_q.push_back(ref_shift(dir, d, amt));
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 64'(bus.out_valid), 64'(exp_v));
    if (!r) begin
      last_data = 64'h0;
    end else if (exp_v) begin
      if (exp_q.size() == 0) check({tag, "_queue"}, 64'(0), 64'(1));
      else last_data = exp_q.pop_front();
    end
    check({tag, "_data"}, bus.shifted_data, last_data);
  endtask

  initial begin
    logic [63:0] ab;
    ab = 64'hAAAA_BBBB_CCCC_DDDD;

    // Reset with a live request: discarded
    step("rst0", 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd3);
    step("rst1", 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd3);

    // Left shifts, back to back
    step("l0", 1'b1, 1'b1, 1'b0, ab, 6'd0);
    check("l0_const", bus.shifted_data, 64'hAAAA_BBBB_CCCC_DDDD);
    step("l1", 1'b1, 1'b1, 1'b0, ab, 6'd1);
    check("l1_const", bus.shifted_data, 64'h5555_7777_9999_BBBA);
    step("l2", 1'b1, 1'b1, 1'b0, ab, 6'd2);
    check("l2_const", bus.shifted_data, 64'hAAAA_EEEF_3333_7774);

    // Right shifts, zero fill
    step("r4", 1'b1, 1'b1, 1'b1, ab, 6'd4);
    check("r4_const", bus.shifted_data, 64'h0AAA_ABBB_BCCC_CDDD);
    step("r63", 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 6'd63);
    check("r63_const", bus.shifted_data, 64'h1);
    step("r0", 1'b1, 1'b1, 1'b1, ab, 6'd0);
    check("r0_const", bus.shifted_data, ab);

    // Extremes
    step("l63", 1'b1, 1'b1, 1'b0, 64'h1, 6'd63);
    check("l63_const", bus.shifted_data, 64'h8000_0000_0000_0000);
    step("l32", 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd32);
    check("l32_const", bus.shifted_data, 64'hFFFF_FFFF_0000_0000);
    step("r32", 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd32);
    check("r32_const", bus.shifted_data, 64'h0000_0000_FFFF_FFFF);

    // Single pulse then idle: data holds, valid drops
    step("pulse", 1'b1, 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 6'd8);
    check("pulse_const", bus.shifted_data, 64'h2345_6789_ABCD_EF00);
    for (int i = 0; i < 3; i++) begin
      step("idle", 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 6'd5);
      check("idle_hold", bus.shifted_data, 64'h2345_6789_ABCD_EF00);
    end

    // Mid-stream reset clears the held result
    step("pre_rst", 1'b1, 1'b1, 1'b1, ab, 6'd16);
    step("mid_rst", 1'b0, 1'b1, 1'b0, ab, 6'd1);
    check("mid_rst_zero", bus.shifted_data, 64'h0);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      step("rand", 1'b1, ($urandom_range(0, 3) != 0), 1'($urandom),
           {$urandom, $urandom}, 6'($urandom));
    end

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/logical_shift_64bit.md
Name: logical_shift_64bit

Overview:
- 64-bit logical (zero-fill) barrel shifter for the ALU shift datapath of the 5-stage pipeline.
- Shifts the 64-bit operand left or right by a 6-bit amount.
- Result is registered: one-cycle latency, with a valid flag travelling alongside.
- Consumed by the ALU result mux in the execute stage.

Parameters:
- None. Data width is fixed at 64 bits; the shift-amount width is fixed at 6 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand and shift fields are valid this cycle.
- shift_dir  input  1  0 = logical left shift, 1 = logical right shift.
- data  input  64  operand to shift.
- shift_amount  input  6  shift distance, 0..63, unsigned.
- out_valid  output  1  shifted_data holds a result captured from an in_valid cycle.
- shifted_data  output  64  registered shift result.

Behaviour:
- Reset
  - On a rising edge of clk with rst_n=0: shifted_data <= 64'h0 and out_valid <= 0.
  - Reset has priority over in_valid.
  - A request presented in the same cycle as reset is discarded.
  - Asserting reset mid-stream clears any result not yet consumed.
- Datapath
  - Purely combinational 6-stage barrel shifter.
  - Stage k shifts by 2^k when shift_amount[k]=1, for k = 0..5.
  - Every bit vacated by the shift is filled with 0, including on right shifts; no sign extension.
- Left shift: result[i] = data[i - shift_amount] for i >= shift_amount, otherwise 0.
- Right shift: result[i] = data[i + shift_amount] for i + shift_amount <= 63, otherwise 0.
- Boundary amounts
  - shift_amount = 0: result equals data in either direction.
  - shift_amount = 63: only one source bit survives (data[0] lands at bit 63 on a left shift; data[63] lands at bit 0 on a right shift).
  - Amounts of 64 or more cannot be expressed on this port.
- Latency
  - When rst_n=1 and in_valid=1 at a rising edge, shifted_data <= result and out_valid <= 1.
  - The result is visible in the cycle after the request.
- Hold
  - When rst_n=1 and in_valid=0, shifted_data keeps its last value and out_valid <= 0.
- Throughput and flow control
  - One new request is accepted per cycle, back to back.
  - There is no backpressure and no stall input.
  - Each output result corresponds exactly to the inputs sampled at the previous rising edge.
- There is no internal state beyond the two output registers.
- No X propagation: all register updates are fully specified for every input combination.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and data=64'hFFFF_FFFF_FFFF_FFFF -> shifted_data=0 and out_valid=0 throughout; after release, the first in_valid produces a result one cycle later.
- Left shifts of data=64'hAAAA_BBBB_CCCC_DDDD, shift_dir=0, one request per cycle:
  - amount 0 -> 64'hAAAA_BBBB_CCCC_DDDD
  - amount 1 -> 64'h5555_7777_9999_BBBA
  - amount 2 -> 64'hAAAA_EEEF_3333_7774
  - each result appears exactly one cycle after its request, with out_valid=1.
- Right shift, zero fill: data=64'hAAAA_BBBB_CCCC_DDDD, shift_dir=1, amount 4 -> 64'h0AAA_ABBB_BCCC_CDDD; data=64'h8000_0000_0000_0000, amount 63 -> 64'h1, with no sign fill.
- Extremes:
  - data=64'h1, left by 63 -> 64'h8000_0000_0000_0000
  - data=64'hFFFF_FFFF_FFFF_FFFF, left by 32 -> 64'hFFFF_FFFF_0000_0000
  - same data, right by 32 -> 64'h0000_0000_FFFF_FFFF
- Hold and valid: one in_valid pulse followed by 3 idle cycles -> out_valid is high for exactly 1 cycle and shifted_data stays unchanged while idle.
- Random: 10k random data/amount/direction requests with random in_valid -> every output matches a reference model of (data << amt) or (data >> amt) on 64 bits, delayed by one cycle.
